// File: rtl/trap_array_sequencer.sv
// rtl/trap_array_sequencer.sv - prime/load/wash valve sequencer for the trap capture array
//
// Drives the five fluidic ports (inlets: cells, buffer, wash; outlets: waste,
// collect) through IDLE -> PRIME -> SET1 -> LOAD -> SET2 -> WASH -> DONE and
// records which traps captured a cell during LOAD.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   start_i               run request (honoured in IDLE only)
//   abort_i               synchronous abort, returns to IDLE with valves closed
//   cfg_prime_i/_load_i/_wash_i  phase lengths in cycles (0 treated as 1)
//   trap_occ_i            raw per-trap occupancy sensors
//   v_cell_o, v_buf_o, v_wash_o  inlet valves
//   v_waste_o, v_coll_o   outlet valves
//   busy_o, done_o        run in progress / one-cycle completion pulse
//   occ_map_o, occ_count_o  sticky capture map and its population count
//   err_timeout_o         LOAD ended on timeout without all traps filled
//
// Build option: define TRAP_DEBOUNCE_EN to require DEB consecutive high
// samples before a trap is marked occupied; otherwise one sample suffices.

module trap_array_sequencer #(
    parameter int N_TRAPS = 8,
    parameter int CNT_W   = 16,
    parameter int DEB     = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic                         abort_i,
    input  logic [CNT_W-1:0]             cfg_prime_i,
    input  logic [CNT_W-1:0]             cfg_load_i,
    input  logic [CNT_W-1:0]             cfg_wash_i,
    input  logic [N_TRAPS-1:0]           trap_occ_i,
    output logic                         v_cell_o,
    output logic                         v_buf_o,
    output logic                         v_wash_o,
    output logic                         v_waste_o,
    output logic                         v_coll_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [N_TRAPS-1:0]           occ_map_o,
    output logic [$clog2(N_TRAPS+1)-1:0] occ_count_o,
    output logic                         err_timeout_o
);

    localparam int OCW = $clog2(N_TRAPS + 1);

    if (DEB < 1) begin : g_deb_check
        $error("DEB must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_SET1,
        S_LOAD,
        S_SET2,
        S_WASH,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   lim_q, lim_d;
    logic [N_TRAPS-1:0] occ_map_q, occ_upd;
    logic [OCW-1:0]     occ_cnt_q;
    logic               err_q;
    logic               busy_q, done_q;
    logic               v_cell_q, v_buf_q, v_wash_q, v_waste_q, v_coll_q;
    logic               phase_end;
    logic               load_full;
    logic               timeout_d;

    // Valve pattern {cell, buf, wash, waste, coll} for each state.
    function automatic logic [4:0] valves_of(input state_e s);
        case (s)
            S_PRIME: valves_of = 5'b01010;
            S_LOAD:  valves_of = 5'b10010;
            S_WASH:  valves_of = 5'b00101;
            default: valves_of = 5'b00000;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] c);
        eff_len = (c == '0) ? CNT_W'(1) : c;
    endfunction

    function automatic logic [OCW-1:0] popcount(input logic [N_TRAPS-1:0] v);
        popcount = '0;
        for (int i = 0; i < N_TRAPS; i++) begin
            popcount = popcount + OCW'(v[i]);
        end
    endfunction

    // cnt_q counts from 0 in the first cycle of a phase; lim_q is at least 1.
    assign phase_end = (cnt_q >= (lim_q - CNT_W'(1)));
    assign load_full = (occ_cnt_q == OCW'(N_TRAPS));

`ifdef TRAP_DEBOUNCE_EN
    localparam int DW = $clog2(DEB + 1);

    logic [DW-1:0] deb_q [N_TRAPS];

    // Per-trap run-length counters; only meaningful while loading.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_TRAPS; i++) begin
                deb_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_TRAPS; i++) begin
                if (state_q == S_LOAD && !abort_i && trap_occ_i[i]) begin
                    if (deb_q[i] != DW'(DEB)) begin
                        deb_q[i] <= deb_q[i] + DW'(1);
                    end
                end else begin
                    deb_q[i] <= '0;
                end
            end
        end
    end

    // The DEB-th consecutive high sample sets the bit in the same edge.
    always_comb begin
        occ_upd = occ_map_q;
        for (int i = 0; i < N_TRAPS; i++) begin
            if (trap_occ_i[i] && (deb_q[i] >= DW'(DEB - 1))) begin
                occ_upd[i] = 1'b1;
            end
        end
    end
`else
    always_comb begin
        occ_upd = occ_map_q | trap_occ_i;
    end
`endif

    always_comb begin
        state_d   = state_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_PRIME;
            S_PRIME: if (phase_end) state_d = S_SET1;
            S_SET1:  state_d = S_LOAD;
            S_LOAD: begin
                // A full map wins over a coincident timeout.
                if (load_full) begin
                    state_d = S_SET2;
                end else if (phase_end) begin
                    state_d   = S_SET2;
                    timeout_d = 1'b1;
                end
            end
            S_SET2:  state_d = S_WASH;
            S_WASH:  if (phase_end) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_i) begin
            state_d   = S_IDLE;
            timeout_d = 1'b0;
        end
    end

    // Phase length is captured once, at phase entry.
    always_comb begin
        case (state_d)
            S_PRIME: lim_d = eff_len(cfg_prime_i);
            S_LOAD:  lim_d = eff_len(cfg_load_i);
            S_WASH:  lim_d = eff_len(cfg_wash_i);
            default: lim_d = CNT_W'(1);
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            lim_q     <= CNT_W'(1);
            occ_map_q <= '0;
            occ_cnt_q <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            v_cell_q  <= 1'b0;
            v_buf_q   <= 1'b0;
            v_wash_q  <= 1'b0;
            v_waste_q <= 1'b0;
            v_coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_d != state_q) begin
                cnt_q <= '0;
                lim_q <= lim_d;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (state_q == S_IDLE && state_d == S_PRIME) begin
                occ_map_q <= '0;
                occ_cnt_q <= '0;
                err_q     <= 1'b0;
            end else if (state_q == S_LOAD && !abort_i) begin
                occ_map_q <= occ_upd;
                occ_cnt_q <= popcount(occ_upd);
                if (timeout_d) begin
                    err_q <= 1'b1;
                end
            end

            // Outputs are decoded from the next state so they align with it.
            busy_q <= (state_d != S_IDLE);
            done_q <= (state_d == S_DONE);
            {v_cell_q, v_buf_q, v_wash_q, v_waste_q, v_coll_q} <= valves_of(state_d);
        end
    end

    assign v_cell_o      = v_cell_q;
    assign v_buf_o       = v_buf_q;
    assign v_wash_o      = v_wash_q;
    assign v_waste_o     = v_waste_q;
    assign v_coll_o      = v_coll_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign occ_map_o     = occ_map_q;
    assign occ_count_o   = occ_cnt_q;
    assign err_timeout_o = err_q;

    // Two inlets open at once would mix streams in the distribution tree.
    a_one_inlet: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0({v_cell_q, v_buf_q, v_wash_q}));

endmodule

// File: tb/tb_trap_array_sequencer.sv
// tb/tb_trap_array_sequencer.sv - directed table-driven bench for trap_array_sequencer

module tb_trap_array_sequencer;

    localparam int N   = 8;
    localparam int CW  = 16;
    localparam int DEB = 4;
`ifdef TRAP_DEBOUNCE_EN
    localparam int LAT = DEB;
    localparam bit DB  = 1'b1;
`else
    localparam int LAT = 1;
    localparam bit DB  = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] cfg_p = '0;
    logic [CW-1:0] cfg_l = '0;
    logic [CW-1:0] cfg_w = '0;
    logic [N-1:0]  trap = '0;
    logic          v_cell, v_buf, v_wash, v_waste, v_coll;
    logic          busy, done, err;
    logic [N-1:0]  occ_map;
    logic [3:0]    occ_count;

    int errors = 0;
    int checks = 0;

    trap_array_sequencer #(.N_TRAPS(N), .CNT_W(CW), .DEB(DEB)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .abort_i      (abort),
        .cfg_prime_i  (cfg_p),
        .cfg_load_i   (cfg_l),
        .cfg_wash_i   (cfg_w),
        .trap_occ_i   (trap),
        .v_cell_o     (v_cell),
        .v_buf_o      (v_buf),
        .v_wash_o     (v_wash),
        .v_waste_o    (v_waste),
        .v_coll_o     (v_coll),
        .busy_o       (busy),
        .done_o       (done),
        .occ_map_o    (occ_map),
        .occ_count_o  (occ_count),
        .err_timeout_o(err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [CW-1:0] p, l, w;
        logic [N-1:0]  mask;
        int            from_c, to_c;
        int            ep, el, ew;
        logic [N-1:0]  eocc;
        int            ecnt;
        logic          eerr;
    } vec_t;

    vec_t vecs [7];

    // One full run: traps show `mask` during LOAD cycles from_c..to_c (0-based).
    task automatic run_vec(input int id, input vec_t v);
        int np, nl, nw, nz, nd, tot, k, bad, guard;
        np = 0; nl = 0; nw = 0; nz = 0; nd = 0; tot = 0; k = 0; bad = 0; guard = 0;
        cfg_p = v.p; cfg_l = v.l; cfg_w = v.w; trap = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        while (busy && guard < 3000) begin
            tot++; guard++;
            if (v_buf)  np++;
            if (v_cell) nl++;
            if (v_wash) nw++;
            if ({v_cell, v_buf, v_wash, v_waste, v_coll} == 5'b0) nz++;
            if (done) nd++;
            if (int'(v_cell) + int'(v_buf) + int'(v_wash) > 1) bad++;
            if (v_cell) begin
                trap = (k >= v.from_c && k <= v.to_c) ? v.mask : '0;
                k++;
            end else begin
                trap = '0;
            end
            step();
        end
        trap = '0;
        chk($sformatf("v%0d_ends", id), int'(busy), 0);
        if (busy) begin
            abort = 1'b1;
            step();
            abort = 1'b0;
        end
        chk($sformatf("v%0d_prime_len", id), np, v.ep);
        chk($sformatf("v%0d_load_len", id), nl, v.el);
        chk($sformatf("v%0d_wash_len", id), nw, v.ew);
        chk($sformatf("v%0d_closed_cycles", id), nz, 3);
        chk($sformatf("v%0d_done_pulses", id), nd, 1);
        chk($sformatf("v%0d_inlet_overlap", id), bad, 0);
        chk($sformatf("v%0d_total_len", id), tot, v.ep + v.el + v.ew + 3);
        chk($sformatf("v%0d_occ_map", id), int'(occ_map), int'(v.eocc));
        chk($sformatf("v%0d_occ_count", id), int'(occ_count), v.ecnt);
        chk($sformatf("v%0d_err_timeout", id), int'(err), int'(v.eerr));
        chk($sformatf("v%0d_done_after", id), int'(done), 0);
    endtask

    initial begin
        int g, nd, np;

        // p, l, w, mask, from, to, exp P, exp L', exp W, exp map, exp count, exp err
        vecs[0] = '{16'd3, 16'd100, 16'd5, 8'hFF, 10, 9999, 3, 11 + LAT, 5, 8'hFF, 8, 1'b0};
        vecs[1] = '{16'd3, 16'd20, 16'd5, 8'h3F, 0, 9999, 3, 20, 5, 8'h3F, 6, 1'b1};
        vecs[2] = '{16'd2, 16'd20, 16'd2, 8'h04, 2, 4, 2, 20, 2,
                    (DB ? 8'h00 : 8'h04), (DB ? 0 : 1), 1'b1};
        vecs[3] = '{16'd0, 16'd0, 16'd0, 8'h00, 0, 9999, 1, 1, 1, 8'h00, 0, 1'b1};
        vecs[4] = '{16'd1, 16'd8, 16'd1, 8'hFF, 0, 9999, 1, LAT + 1, 1, 8'hFF, 8, 1'b0};
        vecs[5] = '{16'd1, CW'(LAT + 1), 16'd1, 8'hFF, 0, 9999, 1, LAT + 1, 1, 8'hFF, 8, 1'b0};
        vecs[6] = '{16'd1, 16'd6, 16'd1, 8'h81, 0, 1, 1, 6, 1,
                    (DB ? 8'h00 : 8'h81), (DB ? 0 : 2), 1'b1};

        #1;
        chk("reset_valves", int'({v_cell, v_buf, v_wash, v_waste, v_coll}), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_occ_map", int'(occ_map), 0);
        chk("reset_occ_count", int'(occ_count), 0);
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            run_vec(i, vecs[i]);
            step();
        end

        // Abort in LOAD cycle 5 with trap 0 already captured.
        cfg_p = 16'd2; cfg_l = 16'd50; cfg_w = 16'd2; trap = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        g = 0;
        while (!v_cell && g < 100) begin
            step();
            g++;
        end
        chk("abort_reached_load", int'(v_cell), 1);
        for (int c = 0; c < 5; c++) begin
            trap = 8'h01;
            step();
        end
        chk("abort_still_load", int'(v_cell), 1);
        abort = 1'b1;
        step();
        chk("abort_valves", int'({v_cell, v_buf, v_wash, v_waste, v_coll}), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_occ_held", int'(occ_map), 1);
        chk("abort_err_held", int'(err), 0);
        abort = 1'b0; trap = '0;
        nd = int'(done);
        for (int c = 0; c < 4; c++) begin
            step();
            nd += int'(done);
        end
        chk("abort_no_done", nd, 0);
        chk("abort_stays_idle", int'(busy), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_clears_occ", int'(occ_map), 0);
        chk("restart_prime_valves", int'({v_cell, v_buf, v_wash, v_waste, v_coll}), 5'b01010);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_in_prime", int'(busy), 0);

        // start and abort together in IDLE.
        start = 1'b1; abort = 1'b1;
        step();
        chk("start_abort_busy", int'(busy), 0);
        chk("start_abort_vbuf", int'(v_buf), 0);
        start = 1'b0; abort = 1'b0;
        step();
        chk("start_abort_still_idle", int'(busy), 0);

        // Config change after PRIME entry must not alter PRIME length.
        cfg_p = 16'd4; cfg_l = 16'd1; cfg_w = 16'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_p = 16'd1;
        np = 0; g = 0;
        while (busy && g < 100) begin
            if (v_buf) np++;
            step();
            g++;
        end
        chk("cfg_midphase_prime_len", np, 4);

        // Reset dropped during WASH clears outputs without a clock edge.
        cfg_p = 16'd1; cfg_l = 16'd1; cfg_w = 16'd10;
        start = 1'b1;
        step();
        start = 1'b0;
        g = 0;
        while (!v_wash && g < 100) begin
            step();
            g++;
        end
        chk("rst_reached_wash", int'(v_wash), 1);
        step();
        step();
        rst_n = 1'b0;
        #2;
        chk("rst_async_valves", int'({v_cell, v_buf, v_wash, v_waste, v_coll}), 0);
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_err", int'(err), 0);
        #1;
        rst_n = 1'b1;
        step();
        step();
        chk("rst_after_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trap_array_sequencer.md
# trap_array_sequencer

Controller that drives the five fluidic ports of the 8-trap cell-capture array (three inlets: cells, buffer, wash; two outlets: waste, collect) through a fixed prime / load / wash sequence. It monitors per-trap occupancy sensors and reports the final capture map. It sits between the host command interface and the valve drivers, as the actuation side of the passive split/trap/merge network.

## Interface
- `N_TRAPS`, default 8: number of trap sensors; must equal the fan-out of the distribution tree.
- `CNT_W`, default 16: width of phase-duration counters and config inputs.
- `DEB`, default 4: consecutive high samples required to mark a trap occupied (only used when debounce is compiled in).
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: run request; sampled only in IDLE.
- `abort` in 1: synchronous abort; overrides all other inputs.
- `cfg_prime` in CNT_W: PRIME duration in cycles.
- `cfg_load` in CNT_W: LOAD timeout in cycles.
- `cfg_wash` in CNT_W: WASH duration in cycles.
- `trap_occ` in N_TRAPS: raw occupancy sensors, one per trap.
- `v_cell` out 1: cell inlet valve (port 1).
- `v_buf` out 1: buffer inlet valve (port 2).
- `v_wash` out 1: wash inlet valve (port 3).
- `v_waste` out 1: waste outlet valve (port 4).
- `v_coll` out 1: collect outlet valve (port 5).
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle completion pulse.
- `occ_map` out N_TRAPS: sticky per-trap occupied flags for the current run.
- `occ_count` out $clog2(N_TRAPS+1): population count of `occ_map`.
- `err_timeout` out 1: LOAD ended by timeout with `occ_count < N_TRAPS`.

## Operation
- States: IDLE, PRIME, SET1, LOAD, SET2, WASH, DONE.
- IDLE: `start=1` → PRIME. Entering PRIME clears `occ_map`, `err_timeout` and the phase counter.
- PRIME: `v_buf=1`, `v_waste=1`. Lasts max(`cfg_prime`,1) cycles, then → SET1.
- SET1 and SET2: all valves closed for exactly 1 cycle (break-before-make). SET1 → LOAD; SET2 → WASH.
- LOAD: `v_cell=1`, `v_waste=1`; `occ_map` updates each cycle.
  - Ends when `occ_count == N_TRAPS` (success), or after max(`cfg_load`,1) cycles (timeout). Either way → SET2.
  - If both conditions occur in the same cycle, success wins and `err_timeout` stays 0.
  - On timeout, `err_timeout` is set.
- WASH: `v_wash=1`, `v_coll=1`. Lasts max(`cfg_wash`,1) cycles, then → DONE.
- DONE: all valves closed, `done=1` for 1 cycle, then → IDLE.
- `occ_map` bits are sticky within a run. They update only in LOAD; a sensor dropping low never clears a bit.
- `abort=1` in any state: next state is IDLE with all valves closed. `occ_map` and `err_timeout` hold their values; no `done` pulse.
- `start` outside IDLE is ignored. `start` and `abort` together in IDLE: abort wins and the FSM stays in IDLE.
- Config inputs are sampled at phase entry; changing them mid-phase has no effect on the current phase.
- The phase counter saturates and never wraps.
- At most one inlet valve is open in any cycle. Violating this is a design error and gets an assertion.

## Timing
- Reset values: all valves 0, `busy`, `done`, `err_timeout` = 0, `occ_map` = 0, `occ_count` = 0, state IDLE.
- All outputs are registered. `start` sampled at edge T gives `busy=1`, `v_buf=1`, `v_waste=1` from T+1.
- Sensor-to-`occ_map` latency:
  - With debounce: DEB cycles of consecutive high sensor.
  - Without debounce: 1 cycle.
- `occ_count` is registered alongside `occ_map`, with the same latency.
- End of LOAD on success: SET2 is entered the cycle after `occ_count` reaches N_TRAPS.
- Full-run length without abort is P+1+L'+1+W+1 cycles, where P, L', W are the effective phase lengths.
- Reset asserted mid-run: outputs return to reset values immediately (asynchronous) and the run is discarded.

## Configuration
- `TRAP_DEBOUNCE_EN` defined: each trap has a saturating counter of width $clog2(DEB+1), cleared whenever its sensor reads low. The trap's `occ_map` bit sets when the counter reaches DEB.
- `TRAP_DEBOUNCE_EN` undefined: no per-trap counters; `occ_map[i]` sets on the first LOAD cycle in which `trap_occ[i]=1`.

## Test plan
- Nominal run, debounce on, DEB=4:
  - Stimulus: `cfg_prime=3`, `cfg_load=100`, `cfg_wash=5`; all traps high from LOAD cycle 10.
  - Required: `occ_map=8'hFF` at LOAD cycle 14, `err_timeout=0`, `done` pulse, total run 3+1+15+1+5+1 cycles.
- Timeout, debounce on: `cfg_load=20`, traps 0–5 high, traps 6–7 low → `occ_map=8'h3F`, `occ_count=6`, `err_timeout=1`, WASH still runs.
- Glitch rejection:
  - Debounce on: trap 2 high for 3 cycles then low → `occ_map[2]=0`.
  - Debounce off: the same stimulus → `occ_map[2]=1`.
- Abort during LOAD cycle 5 → all valves 0 and `busy=0` next cycle, no `done` pulse; the next `start` clears `occ_map`.
- Zero configs: `cfg_prime=cfg_load=cfg_wash=0` → each phase lasts 1 cycle; with no traps occupied, `err_timeout=1`.
- Reset and abort corner cases:
  - `rst_n` dropped in WASH → valves 0 without waiting for a clock edge.
  - `start` and `abort` asserted together in IDLE → stays IDLE.
